// File: rtl/lsu_dmem_if.sv
// Load/store unit data-memory interface: aligns byte/half/word accesses onto a 32-bit bus.
// Define LSU_TIMEOUT_EN to abandon a request or response that takes longer than 255 cycles.
//
// state  | meaning
// IDLE   | no transaction; accepts a new aligned op
// REQ    | dmem_req_o high, waiting for dmem_gnt_i
// WAIT   | load granted, waiting for dmem_rvalid_i
module lsu_dmem_if (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic        we_q, done_q, mis_q;
    logic [1:0]  size_q, off_q;

    logic        op_valid, aligned, start, kill_now;
    logic        st_done, ld_done, tmo, tmo_fire;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, ld_shift, ld_data;

    assign op_valid = valid_i & (is_load_i | is_store_i);
    assign start    = op_valid & aligned & ~flush_i & (state_q == S_IDLE);
    assign kill_now = kill_q | flush_i;

    always_comb begin
        aligned    = 1'b1;
        be_calc    = 4'b1111;
        wdata_calc = wdata_i;
        case (size_i)
            2'd0: begin
                be_calc    = 4'b0001 << addr_i[1:0];
                wdata_calc = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                aligned    = ~addr_i[0];
                be_calc    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata_i[15:0]}};
            end
            default: aligned = (addr_i[1:0] == 2'b00);
        endcase
    end

    assign ld_shift = dmem_rdata_i >> {off_q, 3'b000};
    always_comb begin
        case (size_q)
            2'd0:    ld_data = {24'd0, ld_shift[7:0]};
            2'd1:    ld_data = {16'd0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    assign st_done  = (state_q == S_REQ)  & dmem_gnt_i & we_q & ~kill_now;
    assign ld_done  = (state_q == S_WAIT) & dmem_rvalid_i & ~kill_now;
    // A completing handshake wins over a timeout landing in the same cycle.
    assign tmo_fire = tmo & ~((state_q == S_REQ) & dmem_gnt_i)
                          & ~((state_q == S_WAIT) & dmem_rvalid_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                if (dmem_gnt_i)    state_d = we_q ? S_IDLE : S_WAIT;
                else if (tmo_fire) state_d = S_IDLE;
            end
            S_WAIT: begin
                if (dmem_rvalid_i) state_d = S_IDLE;
                else if (tmo_fire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        kill_d = (state_d != S_IDLE) & kill_now;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            done_q  <= st_done | ld_done;
            mis_q   <= op_valid & ~aligned & ~flush_i & (state_q == S_IDLE);
            if (start) begin
                addr_q  <= {addr_i[31:2], 2'b00};
                be_q    <= be_calc;
                we_q    <= is_store_i;
                wdata_q <= wdata_calc;
                size_q  <= size_i;
                off_q   <= addr_i[1:0];
            end
            if (ld_done) rdata_q <= ld_data;
        end
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;

    // Firing on 254 means the abort edge is the one where the count reaches 255.
    assign tmo = (state_q != S_IDLE) & (cnt_q == 8'd254);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= tmo_fire;
            if (start)                    cnt_q <= '0;
            else if (state_q != S_IDLE)   cnt_q <= cnt_q + 8'd1;
        end
    end
    assign err_o = err_q;
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    assign dmem_req_o   = (state_q == S_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign busy_o       = start | (state_q != S_IDLE);
    assign done_o       = done_q;
    assign rdata_o      = rdata_q;
    assign misaligned_o = mis_q;

endmodule
